// File: rtl/zle_stream_enc.sv
// Zero-length encoder: zero runs collapse into one run token, nonzero words pass as literals; 1-cycle registered output.
// i_b asserts in HOLD or while a pending token is stalled by o_b, and is independent of i_v.
module zle_stream_enc #(
    parameter int W      = 8,
    parameter int MAXRUN = 15,
    parameter int CW     = $clog2(MAXRUN + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_v,
    input  logic [W-1:0] i_d,
    input  logic         i_eos,
    output logic         i_b,
    output logic         o_v,
    output logic [W:0]   o_d,
    output logic         o_eos,
    input  logic         o_b,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } st_t;

    st_t           st;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [W-1:0]  hold_d;
    logic          hold_eos;
    logic          acc;
    logic          zero;
    logic          free;

    assign state   = st;
    assign i_b     = (st == HOLD) | (o_v & o_b);
    assign acc     = i_v & ~i_b;
    assign zero    = (i_d == '0);
    assign free    = ~o_v | ~o_b;
    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            cnt      <= '0;
            hold_d   <= '0;
            hold_eos <= 1'b0;
            o_v      <= 1'b0;
            o_d      <= '0;
            o_eos    <= 1'b0;
        end else begin
            // Drain first; any emit below overrides it so o_v stays high on emit+drain.
            if (o_v && !o_b) begin
                o_v <= 1'b0;
            end
            case (st)
                IDLE: begin
                    if (acc) begin
                        if (!zero) begin
                            o_v   <= 1'b1;
                            o_d   <= {1'b0, i_d};
                            o_eos <= i_eos;
                        end else if (i_eos) begin
                            o_v   <= 1'b1;
                            o_d   <= {1'b1, W'(1)};
                            o_eos <= 1'b1;
                        end else begin
                            cnt <= CW'(1);
                            st  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (acc) begin
                        if (zero) begin
                            if (cnt_inc == CW'(MAXRUN) || i_eos) begin
                                o_v   <= 1'b1;
                                o_d   <= {1'b1, W'(cnt_inc)};
                                o_eos <= i_eos;
                                cnt   <= '0;
                                st    <= IDLE;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            // The literal must wait a cycle behind its run token.
                            o_v      <= 1'b1;
                            o_d      <= {1'b1, W'(cnt)};
                            o_eos    <= 1'b0;
                            hold_d   <= i_d;
                            hold_eos <= i_eos;
                            cnt      <= '0;
                            st       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (free) begin
                        o_v   <= 1'b1;
                        o_d   <= {1'b0, hold_d};
                        o_eos <= hold_eos;
                        st    <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/zle_stream_enc.md
# zle_stream_enc

Parametrised zero-length encoder for TDF valid/backpressure streams: it collapses runs of zero words into single run tokens and passes nonzero words through as literal tokens. It generalises the fixed-width ZLE control FSM with configurable data width and maximum run length, an end-of-stream flush, and registered output. It sits between a word producer and the packer/consumer stage of the ZLE datapath.

## Interface
- `W`, 8: data word width; must be ≥ 2.
- `MAXRUN`, 15: longest run emitted as one token; must be in 2..2^W−1.
- `CW`, clog2(MAXRUN+1): run counter width (derived).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_v`  in  1  input word valid.
- `i_d`  in  W  input word.
- `i_eos`  in  1  input word is the last of its stream; qualified by `i_v`.
- `i_b`  out  1  backpressure to producer; 1 means the word is not accepted this cycle.
- `o_v`  out  1  output token valid.
- `o_d`  out  W+1  output token. `o_d[W]`=1 marks a run token with count in `o_d[W-1:0]`. `o_d[W]`=0 marks a literal.
- `o_eos`  out  1  token is the last of its stream.
- `o_b`  in  1  backpressure from consumer.
- `state`  out  2  FSM state for debug: 0 IDLE, 1 RUN, 2 HOLD.

## Operation
- A transfer occurs when valid=1 and backpressure=0 in the same cycle. Input accept: `acc = i_v & ~i_b`. Output drain: `o_v & ~o_b`.
- `i_b = (state==HOLD) | (o_v & o_b)`. This is combinational from registers and `o_b` only, and does not depend on `i_v`.
- Output register is "free" when `~o_v | ~o_b`. Every emit requires free, which the `i_b` rule already guarantees for accepted inputs.
- States and transitions on `acc`. z = (`i_d`==0).
  - IDLE, nonzero word: emit literal {0,`i_d`} with `o_eos`=`i_eos`; stay IDLE.
  - IDLE, zero word, `i_eos`=1: emit run(1) with eos; stay IDLE.
  - IDLE, zero word, otherwise: count←1; go to RUN.
  - RUN, zero word: n=count+1.
    - If n==MAXRUN or `i_eos`=1: emit run(n) with `o_eos`=`i_eos`; count←0; go to IDLE.
    - Else: count←n with no emit.
  - RUN, nonzero word: emit run(count) with `o_eos`=0. Latch the literal and `i_eos` into the hold register; count←0; go to HOLD.
  - HOLD: input is not accepted. When the output is free, emit the held literal with its eos; go to IDLE.
- A run token never carries count 0 or a count above MAXRUN.
- With no `acc` and no emit: if `o_v`=1 and `o_b`=0, clear `o_v`. Otherwise hold `o_v`, `o_d` and `o_eos` stable.
- A run pending in RUN without eos waits indefinitely. There is no timeout flush.
- Reset values: `o_v`=0, `o_d`=0, `o_eos`=0, state=IDLE, count=0, hold register=0, and therefore `i_b`=0.
- Reset asserted mid-run or in HOLD discards the pending count and the held literal. No token is emitted for them.

## Timing
- Every emit is registered: a token appears on `o_v`/`o_d` in the cycle after the edge that accepted the triggering input. Latency is 1 cycle.
- Run terminated by a nonzero word:
  - edge k emits the run token;
  - earliest edge k+1 (if the consumer accepted the run token at k+1) loads the literal;
  - the next input is accepted at edge k+2 at the earliest.
- Full throughput is one literal per cycle while `o_b`=0.
- Emit and drain in the same cycle: the new token replaces the drained one and `o_v` stays 1.
- While `o_v`=1 and `o_b`=1, all output signals hold stable.

## Test plan
- Literal pass: W=8, MAXRUN=4, `o_b`=0. Input 0x05, 0x07, 0x09 back-to-back → three literals 0x005, 0x007, 0x009 on consecutive cycles, one cycle after each accept; `i_b` stays 0.
- Run split: input 0x00 ×6 then 0x03 → tokens run(4) = 0x104, run(2) = 0x102, literal 0x003. `i_b`=1 for exactly one cycle (HOLD) after 0x03 is accepted.
- EOS flush: input 0x00, 0x00 with `i_eos`=1 on the second → one token 0x102 with `o_eos`=1. Then 0x00 with eos from IDLE → 0x101, eos=1.
- EOS on literal after run: input 0x00, then 0x0A with `i_eos`=1 → 0x101 with eos=0, then 0x00A with eos=1.
- Backpressure: hold `o_b`=1 with a token pending → `i_b`=1, and `o_v`/`o_d` remain constant for 5 cycles. Release `o_b` → token drains and the next input is accepted in the same cycle.
- Reset mid-run: 0x00 ×3, then assert `reset` asynchronously → `o_v`=0, state=0 immediately. After release, input 0x00 with eos → 0x101, with no stale count.
